alu_issue_stage: RTL
====================

// Module: alu_issue_stage
// PURPOSE
//  Decode/issue stage directly upstream of the integer ALU. Accepts RV32I
//  OP/OP-IMM instructions plus register-file read data over valid/ready,
//  decodes funct3/funct7, and builds ALU operands, the 3-bit ALU opcode and
//  is_signed. Results are registered and held in a 2-entry skid buffer so
//  ALU-side backpressure never drops an instruction. Illegal encodings are
//  consumed and reported, never issued.
// PARAMETERS
//  XLEN     32  datapath width; only 32 is supported
//  RADDR_W  5   destination register index width
// PORTS
//  clk            in   1     rising-edge clock
//  rst            in   1     reset, asynchronous, active-high
//  in_valid       in   1     instruction + operands valid
//  in_ready       out  1     stage can accept this cycle
//  in_instr       in   32    raw instruction word
//  in_rs1_data    in   XLEN  rs1 read data
//  in_rs2_data    in   XLEN  rs2 read data
//  out_valid      out  1     ALU issue bundle valid
//  out_ready      in   1     ALU accepts bundle
//  out_operand1   out  XLEN  ALU operand1
//  out_operand2   out  XLEN  ALU operand2
//  out_opcode     out  3     ALU op = funct3
//  out_is_signed  out  1     signed compare / arithmetic right shift
//  out_rd         out  5     destination register
//  err_valid      out  1     one-cycle pulse: illegal instruction consumed
//  err_instr      out  32    offending word; held until next error
// BEHAVIOUR
//  - Reset: out_valid=0, err_valid=0, every data output 0, in_ready=0
//    while rst high; in_ready=1 on the first edge after release.
//  - Transfer on valid&&ready at a rising edge, both sides. out_* bundle is
//    stable while out_valid=1 and out_ready=0.
//  - Latency 1 cycle from accept to out_valid (empty stage). Throughput
//    1/cycle with out_ready held high.
//  - Decode, major opcode 0110011 (OP): op1=rs1; op2=rs2, except SUB
//    (f3=000, f7=0100000): op2 = ~rs2+1 (mod 2^32), opcode 000.
//    Shifts (f3=001/101): op2 = {27'b0, rs2[4:0]}.
//  - 0010011 (OP-IMM): op1=rs1; op2 = sign-extended imm[11:0] (SLTIU too);
//    SLLI/SRLI/SRAI: op2 = {27'b0, instr[24:20]}.
//  - is_signed=1 only for SLT/SLTI (f3=010) and SRA/SRAI (f3=101,
//    f7=0100000); 0 otherwise. rd = instr[11:7]; rd=x0 still issued.
//  - Illegal: any other major opcode; OP with f7 not in {0000000, and
//    0100000 for f3=000/101 only}; SLLI with f7!=0; SRLI/SRAI with f7 not in
//    {0000000,0100000}. Accepted normally, not issued; err_valid=1 next
//    cycle, err_instr updated same edge.
//  - Buffering: output register + 1 skid entry. in_ready = !skid_full
//    (registered). Skid fills when output reg full and out_ready=0 on a
//    legal accept; skid drains into output reg on the out_ready handshake.
//    Order strictly preserved. Illegal accept never occupies an entry.
//  - Simultaneous out handshake + accept with output reg full: incoming
//    word goes to output reg (skid empty) or behind skid (never both full
//    + accept, since in_ready=0 then).
//  - Reset mid-operation: both entries flushed asynchronously, out_valid=0
//    immediately; in-flight instructions are discarded, no err pulse.
// STRUCTURE
//  - Shared package alu_pkg: ALU opcode localparams (ADD=3'b000, SLL=001,
//    SLT=010, SLTU=011, XOR=100, SR=101, OR=110, AND=111), major opcodes
//    OP=7'b0110011, OP_IMM=7'b0010011, F7_ALT=7'b0100000, issue struct type.
//  - Combinational decoder inline; one sub-module alu_skid_buffer
//    (WIDTH param, 2 entries, valid/ready both sides, async active-high rst).
// TESTING
//  - ADDI x1,x0,5 (0x00500093), rs1=0 -> op1=0, op2=5, opcode=000,
//    signed=0, rd=1, out_valid 1 cycle after accept.
//  - SUB x3,x1,x2 (0x402081B3), rs1=10, rs2=3 -> op2=0xFFFFFFFD,
//    opcode=000, rd=3; ADDI imm=-1 (0xFFF00093) -> op2=0xFFFFFFFF.
//  - SRAI x5,x6,4 (0x40435293) -> op2=4, opcode=101, is_signed=1;
//    SLTU rs2=0x0000_0025 -> op2=0x25, is_signed=0.
//  - JAL 0x0000006F and SLLI with f7=0100000 -> err_valid pulse,
//    err_instr=word, no out_valid; following ADDI issues normally.
//  - 4 back-to-back legal words, out_ready=0 for 3 cycles: 2 accepted,
//    in_ready=0; on release all 4 emerge in order, no gaps at out_ready=1.
//  - Assert rst with both entries full -> out_valid=0 same cycle, in_ready=0;
//    after release nothing stale issues.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared constants and types for the ALU issue path:
//                ALU opcodes (funct3 values), RV32I major opcodes, the
//                alternate funct7 encoding, the issue bundle struct and a
//                12-bit immediate sign-extension helper.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

  localparam int c_XLEN = 32;

  // ALU opcodes; these are the RV32I funct3 values
  localparam logic [2:0] c_ALU_ADD  = 3'b000;
  localparam logic [2:0] c_ALU_SLL  = 3'b001;
  localparam logic [2:0] c_ALU_SLT  = 3'b010;
  localparam logic [2:0] c_ALU_SLTU = 3'b011;
  localparam logic [2:0] c_ALU_XOR  = 3'b100;
  localparam logic [2:0] c_ALU_SR   = 3'b101;
  localparam logic [2:0] c_ALU_OR   = 3'b110;
  localparam logic [2:0] c_ALU_AND  = 3'b111;

  // Major opcodes and the alternate funct7 (SUB / SRA / SRAI)
  localparam logic [6:0] c_OPC_OP     = 7'b0110011;
  localparam logic [6:0] c_OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] c_F7_ZERO    = 7'b0000000;
  localparam logic [6:0] c_F7_ALT     = 7'b0100000;

  // Bundle handed to the ALU
  typedef struct packed {
    logic [c_XLEN-1:0] operand1;
    logic [c_XLEN-1:0] operand2;
    logic [2:0]        opcode;
    logic              is_signed;
    logic [4:0]        rd;
  } issue_t;

  localparam int c_ISSUE_W = $bits(issue_t);

  function automatic logic [c_XLEN-1:0] sext12(input logic [11:0] imm);
    return {{(c_XLEN-12){imm[11]}}, imm};
  endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_skid_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_skid_buffer
//  Description : Two-entry valid/ready buffer: an output register plus one
//                skid entry. Input ready is registered (high whenever the
//                skid entry is empty), so upstream never sees a combinational
//                path from out_ready. Strict FIFO order.
//  Ports       : clk, rst (async, active-high)
//                in_valid / in_ready / in_data    upstream handshake
//                out_valid / out_ready / out_data downstream handshake
//  Revision    : 1.0  initial release
// ============================================================================
module alu_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             out_valid_q,  out_valid_d;
  logic [WIDTH-1:0] out_data_q,   out_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q,  skid_data_d;
  logic             in_ready_q;
  logic             push;
  logic             pop;

  assign push = in_valid && in_ready_q;
  assign pop  = out_valid_q && out_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (!out_valid_q || pop) begin
      // Output register is free this edge: the oldest word moves in.
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = push;
        if (push) begin
          skid_data_d = in_data;
        end
      end else begin
        out_valid_d = push;
        if (push) begin
          out_data_d = in_data;
        end
      end
    end else if (push) begin
      // Output register stalled: park the new word in the skid entry.
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      in_ready_q   <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      in_ready_q   <= !skid_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule : alu_skid_buffer
`default_nettype wire

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue_stage
//  Description : Decode/issue stage in front of the integer ALU. Decodes
//                RV32I OP / OP-IMM words, builds operand1/operand2, the ALU
//                opcode (funct3) and is_signed, and buffers the bundle in a
//                two-entry skid buffer. Illegal words are consumed, never
//                issued, and reported with a one-cycle err_valid pulse.
//  Ports       : clk, rst (async, active-high)
//                in_valid/in_ready, in_instr, in_rs1_data, in_rs2_data
//                out_valid/out_ready, out_operand1, out_operand2,
//                out_opcode, out_is_signed, out_rd
//                err_valid (pulse), err_instr (held until next error)
//  Revision    : 1.0  initial release
// ============================================================================
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN    = 32,   // only 32 is supported
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_instr,
  input  logic [XLEN-1:0]    in_rs1_data,
  input  logic [XLEN-1:0]    in_rs2_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_operand1,
  output logic [XLEN-1:0]    out_operand2,
  output logic [2:0]         out_opcode,
  output logic               out_is_signed,
  output logic [RADDR_W-1:0] out_rd,
  output logic               err_valid,
  output logic [31:0]        err_instr
);

  // Instruction fields
  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       f3_is_shift;

  assign opc         = in_instr[6:0];
  assign f3          = in_instr[14:12];
  assign f7          = in_instr[31:25];
  assign f3_is_shift = (f3 == c_ALU_SLL) || (f3 == c_ALU_SR);

  // Decoder
  logic   legal;
  issue_t dec;

  always_comb begin
    legal         = 1'b0;
    dec.operand1  = in_rs1_data;
    dec.operand2  = in_rs2_data;
    dec.opcode    = f3;
    dec.rd        = in_instr[11:7];
    // SLT/SLTI always signed; SR only with the alternate funct7 (SRA/SRAI)
    dec.is_signed = (f3 == c_ALU_SLT) || ((f3 == c_ALU_SR) && (f7 == c_F7_ALT));

    if (opc == c_OPC_OP) begin
      legal = (f7 == c_F7_ZERO) ||
              ((f7 == c_F7_ALT) && ((f3 == c_ALU_ADD) || (f3 == c_ALU_SR)));
      if (f3_is_shift) begin
        dec.operand2 = {27'b0, in_rs2_data[4:0]};
      end else if ((f3 == c_ALU_ADD) && (f7 == c_F7_ALT)) begin
        // SUB is executed by the ALU adder on a negated operand
        dec.operand2 = ~in_rs2_data + 32'd1;
      end
    end else if (opc == c_OPC_OP_IMM) begin
      if (f3 == c_ALU_SLL) begin
        legal        = (f7 == c_F7_ZERO);
        dec.operand2 = {27'b0, in_instr[24:20]};
      end else if (f3 == c_ALU_SR) begin
        legal        = (f7 == c_F7_ZERO) || (f7 == c_F7_ALT);
        dec.operand2 = {27'b0, in_instr[24:20]};
      end else begin
        legal        = 1'b1;
        dec.operand2 = sext12(in_instr[31:20]);
      end
    end
  end

  // Handshake and error reporting
  logic   accept;
  logic   buf_in_valid;
  issue_t buf_out;
  logic   err_valid_q, err_valid_d;
  logic [31:0] err_instr_q, err_instr_d;

  assign accept       = in_valid && in_ready;
  // Illegal words complete the upstream handshake but never enter the buffer
  assign buf_in_valid = in_valid && legal;

  always_comb begin
    err_valid_d = accept && !legal;
    err_instr_d = err_valid_d ? in_instr : err_instr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_valid_q <= 1'b0;
      err_instr_q <= '0;
    end else begin
      err_valid_q <= err_valid_d;
      err_instr_q <= err_instr_d;
    end
  end

  alu_skid_buffer #(
    .WIDTH (c_ISSUE_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (buf_in_valid),
    .in_ready  (in_ready),
    .in_data   (dec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (buf_out)
  );

  assign out_operand1  = buf_out.operand1;
  assign out_operand2  = buf_out.operand2;
  assign out_opcode    = buf_out.opcode;
  assign out_is_signed = buf_out.is_signed;
  assign out_rd        = buf_out.rd;
  assign err_valid     = err_valid_q;
  assign err_instr     = err_instr_q;

endmodule : alu_issue_stage
`default_nettype wire
